// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: ALUOp encodings, RISC-V major opcodes,
// and the per-stage control bundle carried down the pipeline.
package ctrl_pkg;

    localparam logic [1:0] ADD_OPCODE    = 2'b00;
    localparam logic [1:0] SUB_OPCODE    = 2'b01;
    localparam logic [1:0] R_TYPE_OPCODE = 2'b10;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_2_reg;
        logic reg_write;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_bundle_t;

    // A bubble does nothing: add with no memory access and no writeback.
    localparam ctrl_bundle_t NOP_BUNDLE = '{
        ex:  '{alu_op: ADD_OPCODE, alu_src: 1'b0},
        mem: '{mem_read: 1'b0, mem_write: 1'b0},
        wb:  '{mem_2_reg: 1'b0, reg_write: 1'b0}
    };

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register. A bubble overrides load and forces the
// NOP value; reset also yields the NOP value.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   NOP_VAL = '0
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q <= NOP_VAL;
        end else if (bubble) begin
            q <= NOP_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Carries decoded control through ID/EX, EX/MEM and MEM/WB, stalls on
// load-use hazards and flushes IF/ID on a taken branch or jump.
module hazard_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [1:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_2_reg,
    input  logic             id_reg_write,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_if_flush,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_2_reg,
    output logic             ex_reg_write,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_mem_2_reg,
    output logic             mem_reg_write,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_mem_2_reg,
    output logic             wb_reg_write,
    output logic [REG_W-1:0] wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int IDEX_W  = $bits(ctrl_bundle_t) + REG_W;
    localparam int EXMEM_W = $bits(mem_ctrl_t) + $bits(wb_ctrl_t) + REG_W;
    localparam int MEMWB_W = $bits(wb_ctrl_t) + REG_W;
    localparam logic [IDEX_W-1:0] IDEX_NOP = {NOP_BUNDLE, {REG_W{1'b0}}};

    ctrl_bundle_t       id_b;
    ctrl_bundle_t       ex_b;
    mem_ctrl_t          mem_m;
    wb_ctrl_t           mem_w;
    wb_ctrl_t           wb_w;
    logic [IDEX_W-1:0]  idex_q;
    logic [EXMEM_W-1:0] exmem_q;
    logic [MEMWB_W-1:0] memwb_q;
    logic               hz;

    assign id_b = '{
        ex:  '{alu_op: id_alu_op, alu_src: id_alu_src},
        mem: '{mem_read: id_mem_read, mem_write: id_mem_write},
        wb:  '{mem_2_reg: id_mem_2_reg, reg_write: id_reg_write}
    };

    // Bubbles carry rd=0, so a bubble in EX can never itself raise a hazard.
    assign hz = ex_b.mem.mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign pc_write    = ~hz;
    assign if_id_write = ~hz;
    assign if_id_flush = id_if_flush & (id_branch | id_jump) & ~hz;

    ctrl_stage_reg #(.W(IDEX_W), .NOP_VAL(IDEX_NOP)) u_id_ex (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (1'b1),
        .bubble (hz),
        .d      ({id_b, id_rd}),
        .q      (idex_q)
    );

    ctrl_stage_reg #(.W(EXMEM_W)) u_ex_mem (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .d      ({ex_b.mem, ex_b.wb, ex_rd}),
        .q      (exmem_q)
    );

    ctrl_stage_reg #(.W(MEMWB_W)) u_mem_wb (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .d      ({mem_w, mem_rd}),
        .q      (memwb_q)
    );

    assign {ex_b, ex_rd}         = idex_q;
    assign {mem_m, mem_w, mem_rd} = exmem_q;
    assign {wb_w, wb_rd}         = memwb_q;

    assign ex_alu_op     = ex_b.ex.alu_op;
    assign ex_alu_src    = ex_b.ex.alu_src;
    assign ex_mem_read   = ex_b.mem.mem_read;
    assign ex_mem_write  = ex_b.mem.mem_write;
    assign ex_mem_2_reg  = ex_b.wb.mem_2_reg;
    assign ex_reg_write  = ex_b.wb.reg_write;
    assign mem_mem_read  = mem_m.mem_read;
    assign mem_mem_write = mem_m.mem_write;
    assign mem_mem_2_reg = mem_w.mem_2_reg;
    assign mem_reg_write = mem_w.reg_write;
    assign wb_mem_2_reg  = wb_w.mem_2_reg;
    assign wb_reg_write  = wb_w.reg_write;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
        end else if (hz && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: a driver issues one instruction bundle
// per cycle and queues the expected outputs; a monitor checks each cycle.
module tb_hazard_ctrl_pipe;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int OW    = 3 + 7 + REG_W + 4 + REG_W + 2 + REG_W + CNT_W;

    // ctrl = {alu_op[1:0], alu_src, mem_read, mem_write, mem_2_reg, reg_write}
    typedef struct packed {
        logic [6:0]       ctrl;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             br;
        logic             jmp;
        logic             fl;
    } instr_t;

    localparam int I_NOP  = 0;
    localparam int I_ADDI = 1;
    localparam int I_LW7  = 2;
    localparam int I_ADD7 = 3;
    localparam int I_LW0  = 4;
    localparam int I_USE0 = 5;
    localparam int I_USE8 = 6;
    localparam int I_BEQ  = 7;
    localparam int I_BEQ7 = 8;

    instr_t tbl [9];

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic [1:0]       id_alu_op;
    logic             id_alu_src, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write;
    logic             id_branch, id_jump, id_if_flush;
    logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
    logic             pc_write, if_id_write, if_id_flush;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write;
    logic [REG_W-1:0] ex_rd;
    logic             mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write;
    logic [REG_W-1:0] mem_rd;
    logic             wb_mem_2_reg, wb_reg_write;
    logic [REG_W-1:0] wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    logic [OW-1:0] exp_q[$];
    int            tag_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    event          async_ev;

    hazard_ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_2_reg  (id_mem_2_reg),
        .id_reg_write  (id_reg_write),
        .id_branch     (id_branch),
        .id_jump       (id_jump),
        .id_if_flush   (id_if_flush),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_2_reg  (ex_mem_2_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_mem_2_reg (mem_mem_2_reg),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_mem_2_reg  (wb_mem_2_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .stall_cnt     (stall_cnt)
    );

    // Clock and reset
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] exp_vec(input logic pcw, input logic fl,
                                              input int e, input int m, input int w,
                                              input logic [CNT_W-1:0] cnt);
        return {pcw, pcw, fl, tbl[e].ctrl, tbl[e].rd, tbl[m].ctrl[3:0], tbl[m].rd,
                tbl[w].ctrl[1:0], tbl[w].rd, cnt};
    endfunction

    function automatic logic [OW-1:0] act_vec();
        return {pc_write, if_id_write, if_id_flush, ex_alu_op, ex_alu_src, ex_mem_read,
                ex_mem_write, ex_mem_2_reg, ex_reg_write, ex_rd, mem_mem_read, mem_mem_write,
                mem_mem_2_reg, mem_reg_write, mem_rd, wb_mem_2_reg, wb_reg_write, wb_rd,
                stall_cnt};
    endfunction

    // Driver tasks
    task automatic drive(input int idx);
        id_alu_op    = tbl[idx].ctrl[6:5];
        id_alu_src   = tbl[idx].ctrl[4];
        id_mem_read  = tbl[idx].ctrl[3];
        id_mem_write = tbl[idx].ctrl[2];
        id_mem_2_reg = tbl[idx].ctrl[1];
        id_reg_write = tbl[idx].ctrl[0];
        id_rs1       = tbl[idx].rs1;
        id_rs2       = tbl[idx].rs2;
        id_rd        = tbl[idx].rd;
        id_branch    = tbl[idx].br;
        id_jump      = tbl[idx].jmp;
        id_if_flush  = tbl[idx].fl;
    endtask

    task automatic step(input int tag, input bit rel, input int idx, input logic pcw,
                        input logic fl, input int e, input int m, input int w,
                        input logic [CNT_W-1:0] cnt);
        @(posedge clk);
        #2;
        if (rel) arst_n = 1'b1;
        drive(idx);
        exp_q.push_back(exp_vec(pcw, fl, e, m, w, cnt));
        tag_q.push_back(tag);
    endtask

    // Scoreboard monitor
    initial begin
        logic [OW-1:0] exp_v;
        logic [OW-1:0] act_v;
        int            tag;
        forever begin
            @(negedge clk or async_ev);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = tag_q.pop_front();
                act_v = act_vec();
                n_checks++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL step%0d: got %h expected %h", tag, act_v, exp_v);
            end
        end
    end

    initial begin
        tbl[I_NOP]  = '{ctrl: 7'b00_0_0_0_0_0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,  br: 0, jmp: 0, fl: 0};
        tbl[I_ADDI] = '{ctrl: 7'b00_1_0_0_0_1, rs1: 5'd1, rs2: 5'd0, rd: 5'd5,  br: 0, jmp: 0, fl: 0};
        tbl[I_LW7]  = '{ctrl: 7'b00_1_1_0_1_1, rs1: 5'd2, rs2: 5'd0, rd: 5'd7,  br: 0, jmp: 0, fl: 0};
        tbl[I_ADD7] = '{ctrl: 7'b10_0_0_0_0_1, rs1: 5'd7, rs2: 5'd3, rd: 5'd9,  br: 0, jmp: 0, fl: 0};
        tbl[I_LW0]  = '{ctrl: 7'b00_1_1_0_1_1, rs1: 5'd2, rs2: 5'd0, rd: 5'd0,  br: 0, jmp: 0, fl: 0};
        tbl[I_USE0] = '{ctrl: 7'b10_0_0_0_0_1, rs1: 5'd0, rs2: 5'd0, rd: 5'd10, br: 0, jmp: 0, fl: 0};
        tbl[I_USE8] = '{ctrl: 7'b10_0_0_0_0_1, rs1: 5'd1, rs2: 5'd8, rd: 5'd11, br: 0, jmp: 0, fl: 0};
        tbl[I_BEQ]  = '{ctrl: 7'b01_0_0_0_0_0, rs1: 5'd4, rs2: 5'd6, rd: 5'd0,  br: 1, jmp: 0, fl: 1};
        tbl[I_BEQ7] = '{ctrl: 7'b01_0_0_0_0_0, rs1: 5'd7, rs2: 5'd6, rd: 5'd0,  br: 1, jmp: 0, fl: 1};

        // Reset held with arbitrary live inputs.
        drive(I_LW7);
        repeat (2) @(posedge clk);
        #2 drive(I_ADD7);
        @(posedge clk);

        //   tag rel instr   pcw fl ex      mem     wb      cnt
        step(0,  1, I_NOP,  1, 0, I_NOP,  I_NOP,  I_NOP,  0);
        // Latency of a single ADDI
        step(1,  0, I_ADDI, 1, 0, I_NOP,  I_NOP,  I_NOP,  0);
        step(2,  0, I_NOP,  1, 0, I_ADDI, I_NOP,  I_NOP,  0);
        step(3,  0, I_NOP,  1, 0, I_NOP,  I_ADDI, I_NOP,  0);
        step(4,  0, I_NOP,  1, 0, I_NOP,  I_NOP,  I_ADDI, 0);
        // Load-use: one bubble, ADD re-presented
        step(5,  0, I_LW7,  1, 0, I_NOP,  I_NOP,  I_NOP,  0);
        step(6,  0, I_ADD7, 0, 0, I_LW7,  I_NOP,  I_NOP,  0);
        step(7,  0, I_ADD7, 1, 0, I_NOP,  I_LW7,  I_NOP,  1);
        step(8,  0, I_NOP,  1, 0, I_ADD7, I_NOP,  I_LW7,  1);
        // No false hazard on rd=0 or unrelated rs2
        step(9,  0, I_LW0,  1, 0, I_NOP,  I_ADD7, I_NOP,  1);
        step(10, 0, I_USE0, 1, 0, I_LW0,  I_NOP,  I_ADD7, 1);
        step(11, 0, I_LW7,  1, 0, I_USE0, I_LW0,  I_NOP,  1);
        step(12, 0, I_USE8, 1, 0, I_LW7,  I_USE0, I_LW0,  1);
        // Taken branch without hazard flushes for one cycle
        step(13, 0, I_BEQ,  1, 1, I_USE8, I_LW7,  I_USE0, 1);
        step(14, 0, I_NOP,  1, 0, I_BEQ,  I_USE8, I_LW7,  1);
        // Branch coinciding with stall: flush deferred a cycle
        step(15, 0, I_LW7,  1, 0, I_NOP,  I_BEQ,  I_USE8, 1);
        step(16, 0, I_BEQ7, 0, 0, I_LW7,  I_NOP,  I_BEQ,  1);
        step(17, 0, I_BEQ7, 1, 1, I_NOP,  I_LW7,  I_NOP,  2);
        step(18, 0, I_NOP,  1, 0, I_BEQ7, I_NOP,  I_LW7,  2);
        // Async reset between edges while stalled
        step(19, 0, I_LW7,  1, 0, I_NOP,  I_BEQ7, I_NOP,  2);
        step(20, 0, I_ADD7, 0, 0, I_LW7,  I_NOP,  I_BEQ7, 2);
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        exp_q.push_back(exp_vec(1, 0, I_NOP, I_NOP, I_NOP, 0));
        tag_q.push_back(21);
        ->async_ev;
        step(22, 1, I_ADD7, 1, 0, I_NOP,  I_NOP,  I_NOP,  0);
        step(23, 0, I_NOP,  1, 0, I_ADD7, I_NOP,  I_NOP,  0);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
